mdv_writer: RTL and testbench

//  Microdrive write path. Accepts bytes from the CPU's transmit register while the

---
 rtl/mdv_writer.sv | 185 ++++++++++++++++++
 tb/tb_mdv_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdv_writer.sv
`timescale 1ns/1ps
// Microdrive write path: paced byte capture, preamble strip, big-endian word packing,
// and a small word FIFO toward the drive RAM image.

// Generic synchronous FIFO with valid/ready on both sides.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module mdv_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign out_vld = (cnt != '0);
  assign pop     = out_vld & out_rdy;
  assign in_rdy  = (cnt != FULL_CNT) | pop;
  assign push    = in_vld & in_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// Microdrive write path top.
// Latency: word pushed on the second byte's tick edge; mem_wr_req rises the cycle after.
// Backpressure: none toward the CPU; a full FIFO drops the word and raises overrun.
module mdv_writer #(
  parameter int          CLK_HZ         = 21000000,
  parameter int          BIT_RATE       = 200000,
  parameter logic [24:0] BASE_ADDR      = 25'h380000,
  parameter int          PREAMBLE_BYTES = 12,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        wr_gate,
  input  logic        tx_wr,
  input  logic [7:0]  tx_data,
  output logic        tx_empty,
  output logic        overrun,
  output logic        busy,
  input  logic [24:0] rd_addr,
  input  logic [24:0] img_end,
  output logic        mem_wr_req,
  input  logic        mem_wr_ack,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_dout
);
  localparam int PERIOD = CLK_HZ * 8 / BIT_RATE;
  localparam int TW     = $clog2(PERIOD);
  localparam int PW     = $clog2(PREAMBLE_BYTES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD - 1);
  localparam logic [PW-1:0] P_DONE = PW'(PREAMBLE_BYTES);

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wentry_t;

  logic          gate, gate_q, rise, fall, tick;
  logic [TW-1:0] timer;
  logic [PW-1:0] pcnt;
  logic          pre_done, store;
  logic [7:0]    hold, hi, tick_byte;
  logic          half;
  logic [24:0]   waddr, waddr_next;
  logic          push_vld, push_rdy, head_vld;
  wentry_t       push_dat, head;

  assign gate      = sel & wr_gate;
  assign rise      = gate & ~gate_q;
  assign fall      = ~gate & gate_q;
  assign tick      = gate & ~rise & (timer == T_LAST);
  assign pre_done  = (pcnt == P_DONE);
  assign tick_byte = tx_empty ? 8'h00 : hold;
  assign store     = tick & pre_done;

  // A gate fall flushes a dangling high byte as {hi, 00}.
  assign push_vld      = half & (store | fall);
  assign push_dat.addr = waddr;
  assign push_dat.data = fall ? {hi, 8'h00} : {hi, tick_byte};
  assign waddr_next    = (waddr >= img_end) ? BASE_ADDR : waddr + 25'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_q   <= 1'b0;
      timer    <= '0;
      pcnt     <= '0;
      hold     <= 8'h00;
      tx_empty <= 1'b1;
      hi       <= 8'h00;
      half     <= 1'b0;
      waddr    <= BASE_ADDR;
      overrun  <= 1'b0;
    end else begin
      gate_q <= gate;

      if (!gate || rise || tick) timer <= '0;
      else                       timer <= timer + 1'b1;

      if (rise)                  pcnt <= '0;
      else if (tick && !pre_done) pcnt <= pcnt + 1'b1;

      // The tick consumes the pre-cycle holding state, so a same-cycle write always lands.
      if (!gate) begin
        tx_empty <= 1'b1;
      end else if (tx_wr && (tx_empty || tick)) begin
        hold     <= tx_data;
        tx_empty <= 1'b0;
      end else if (tick) begin
        tx_empty <= 1'b1;
      end

      if (rise || fall) begin
        half <= 1'b0;
      end else if (store) begin
        if (!half) hi <= tick_byte;
        half <= ~half;
      end

      if (rise)          waddr <= rd_addr;
      else if (push_vld) waddr <= waddr_next;

      if (rise)
        overrun <= 1'b0;
      else if ((gate && tx_wr && !tx_empty && !tick) || (tick && tx_empty) ||
               (push_vld && !push_rdy))
        overrun <= 1'b1;
    end
  end

  mdv_fifo #(
    .W     ($bits(wentry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (push_vld),
    .in_rdy  (push_rdy),
    .in_dat  (push_dat),
    .out_vld (head_vld),
    .out_rdy (mem_wr_ack),
    .out_dat (head)
  );

  assign mem_wr_req = head_vld;
  assign mem_addr   = head_vld ? head.addr : BASE_ADDR;
  assign mem_dout   = head_vld ? head.data : 16'h0000;
  assign busy       = gate | head_vld;
endmodule

// File: tb/tb_mdv_writer.sv
`timescale 1ns/1ps
// Bench for mdv_writer: directed byte sessions against a word-level session model.
module tb_mdv_writer;
  localparam int          P    = 40;          // 1 MHz clock, 200 kbit/s -> 40 clocks/byte
  localparam logic [24:0] BASE = 25'h380000;

  typedef struct packed {
    logic [24:0] a;
    logic [15:0] d;
  } wr_t;

  logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, wr_gate = 1'b0, tx_wr = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [24:0] rd_addr = BASE, img_end = 25'h3FFFFF;
  logic        mem_wr_ack = 1'b0;
  logic        tx_empty, overrun, busy, mem_wr_req;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout;

  wr_t        exp_q[$], got_q[$], mdl_q[$];
  logic [7:0] sb[$];
  bit         sp[$], sd[$];
  bit         auto_ack = 1'b0;
  bit         exp_ovr;
  int         tests_run = 0, fails = 0;

  always #5 clk = ~clk;

  mdv_writer #(
    .CLK_HZ(1000000), .BIT_RATE(200000), .BASE_ADDR(BASE),
    .PREAMBLE_BYTES(12), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .wr_gate(wr_gate), .tx_wr(tx_wr),
    .tx_data(tx_data), .tx_empty(tx_empty), .overrun(overrun), .busy(busy),
    .rd_addr(rd_addr), .img_end(img_end), .mem_wr_req(mem_wr_req),
    .mem_wr_ack(mem_wr_ack), .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare process: checks head stability while unacked, and each handed-over word.
  initial begin : cmp
    wr_t prev;
    wr_t e;
    bit  prev_hold;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_hold && mem_wr_req) begin
        check("hold_addr", mem_addr, prev.a);
        check("hold_data", mem_dout, prev.d);
      end
      if (auto_ack && mem_wr_req && !reset) begin
        got_q.push_back({mem_addr, mem_dout});
        if (exp_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL extra_write: got %0h@%0h, expected no write", mem_dout, mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", mem_addr, e.a);
          check("wr_data", mem_dout, e.d);
        end
        mem_wr_ack = 1'b1;
      end else begin
        mem_wr_ack = 1'b0;
      end
      prev_hold = mem_wr_req && !mem_wr_ack;
      prev      = {mem_addr, mem_dout};
    end
  end

  task automatic add(input logic [7:0] b, input bit present, input bit dbl);
    sb.push_back(b);
    sp.push_back(present);
    sd.push_back(dbl);
  endtask

  task automatic clear_stream();
    sb.delete(); sp.delete(); sd.delete();
    got_q.delete(); mdl_q.delete();
  endtask

  task automatic add_preamble();
    for (int i = 0; i < 12; i++) add(8'h00, 1'b1, 1'b0);
  endtask

  // One gate-open session: model the expected words, then drive one byte per period.
  task automatic run_session(input logic [24:0] ra, input logic [24:0] ie,
                             input int cap, input bit drain);
    int          nq;
    int          n;
    bit          half;
    bit          do_push;
    logic [7:0]  hi, b;
    logic [15:0] w;
    logic [24:0] a;
    nq = 0; half = 1'b0; hi = 8'h00; a = ra; exp_ovr = 1'b0;
    for (int i = 0; i <= sb.size(); i++) begin
      do_push = 1'b0;
      w = 16'h0000;
      if (i == sb.size()) begin
        if (half) begin do_push = 1'b1; w = {hi, 8'h00}; end
      end else begin
        b = sp[i] ? sb[i] : 8'h00;
        if (!sp[i] || sd[i]) exp_ovr = 1'b1;
        if (i >= 12) begin
          if (!half) begin hi = b; half = 1'b1; end
          else begin do_push = 1'b1; w = {hi, b}; half = 1'b0; end
        end
      end
      if (do_push) begin
        if (cap >= 0 && nq >= cap) exp_ovr = 1'b1;
        else begin
          exp_q.push_back({a, w});
          mdl_q.push_back({a, w});
          nq++;
        end
        a = (a >= ie) ? BASE : a + 25'd1;
      end
    end

    rd_addr = ra;
    img_end = ie;
    @(negedge clk);
    sel = 1'b1; wr_gate = 1'b1;
    for (int k = 0; k < sb.size(); k++) begin
      for (int j = 1; j <= P; j++) begin
        @(negedge clk);
        tx_wr   = (sp[k] && j == 5) || (sd[k] && j == 15);
        tx_data = (j == 15) ? 8'hEE : sb[k];
      end
    end
    @(negedge clk);
    wr_gate = 1'b0;
    if (drain) begin
      n = 0;
      while ((exp_q.size() != 0 || mem_wr_req) && n < 300) begin
        @(negedge clk);
        n++;
      end
      check("drain_in_time", n < 300, 1);
      check("overrun", overrun, exp_ovr);
      check("busy_idle", busy, 0);
    end
  endtask

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_tx_empty", tx_empty, 1);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_req", mem_wr_req, 0);
    check("rst_addr", mem_addr, BASE);
    check("rst_dout", mem_dout, 0);
    auto_ack = 1'b1;

    // No bytes at all: two underrun zero bytes make one word.
    clear_stream();
    for (int i = 0; i < 14; i++) add(8'h00, 1'b0, 1'b0);
    run_session(25'h380020, 25'h3FFFFF, -1, 1);
    check("t2_mdl", mdl_q[0], {25'h380020, 16'h0000});
    check("t2_count", got_q.size(), 1);
    check("t2_ovr", overrun, 1);

    // Full preamble then AA,55; the gate rise clears the earlier overrun.
    clear_stream();
    for (int i = 0; i < 10; i++) add(8'h00, 1'b1, 1'b0);
    add(8'hFF, 1'b1, 1'b0); add(8'hFF, 1'b1, 1'b0);
    add(8'hAA, 1'b1, 1'b0); add(8'h55, 1'b1, 1'b0);
    run_session(25'h380010, 25'h3FFFFF, -1, 1);
    check("t1_mdl_n", mdl_q.size(), 1);
    check("t1_mdl", mdl_q[0], {25'h380010, 16'hAA55});
    check("t1_got", got_q[0], {25'h380010, 16'hAA55});
    check("t1_ovr", overrun, 0);

    // Second write within one period is ignored.
    clear_stream();
    add_preamble();
    add(8'h12, 1'b1, 1'b1); add(8'h34, 1'b1, 1'b0);
    run_session(25'h380030, 25'h3FFFFF, -1, 1);
    check("t3_got", got_q[0], {25'h380030, 16'h1234});
    check("t3_ovr", overrun, 1);

    // Address wrap at img_end.
    clear_stream();
    add_preamble();
    for (int i = 1; i <= 16; i++) add(8'(i), 1'b1, 1'b0);
    run_session(25'h380011, 25'h380011, -1, 1);
    check("t4_count", got_q.size(), 8);
    check("t4_w0", got_q[0], {25'h380011, 16'h0102});
    check("t4_w1", got_q[1], {25'h380000, 16'h0304});

    // FIFO fills with ack held low; extra words dropped.
    auto_ack = 1'b0;
    clear_stream();
    add_preamble();
    for (int i = 0; i < 20; i++) add(8'h40 + 8'(i), 1'b1, 1'b0);
    run_session(25'h380100, 25'h3FFFFF, 4, 0);
    repeat (5) @(negedge clk);
    check("t5_mdl_n", mdl_q.size(), 4);
    check("t5_req", mem_wr_req, 1);
    check("t5_busy", busy, 1);
    check("t5_ovr", overrun, 1);
    auto_ack = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || mem_wr_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_drain", n < 50, 1);
    check("t5_req_low", mem_wr_req, 0);
    check("t5_count", got_q.size(), 4);
    check("t5_w3", got_q[3], {25'h380103, 16'h4647});

    // Gate fall with a dangling high byte.
    clear_stream();
    add_preamble();
    add(8'hA1, 1'b1, 1'b0); add(8'hB2, 1'b1, 1'b0); add(8'hC3, 1'b1, 1'b0);
    run_session(25'h380200, 25'h3FFFFF, -1, 1);
    check("t6_count", got_q.size(), 2);
    check("t6_w0", got_q[0], {25'h380200, 16'hA1B2});
    check("t6_w1", got_q[1], {25'h380201, 16'hC300});

    // Reset with queued words discards them.
    auto_ack = 1'b0;
    clear_stream();
    add_preamble();
    for (int i = 0; i < 4; i++) add(8'h70 + 8'(i), 1'b1, 1'b0);
    run_session(25'h380300, 25'h3FFFFF, 4, 0);
    repeat (3) @(negedge clk);
    check("t7_req_before", mem_wr_req, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t7_req_reset", mem_wr_req, 0);
    check("t7_addr_reset", mem_addr, BASE);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t7_req_after", mem_wr_req, 0);
    check("t7_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
